mmu_bus_arbiter: RTL and testbench

Two-requester TileLink-UL arbiter sharing one physical bus between the instruction-side and data-side MMUs (each MMU's `phy_bus` master port) ahead of the memory crossbar. It grants one requester at a time and holds the grant from A-channel issue until the matching D-channel beat completes, so page-table walks and translated accesses are never interleaved. A D-channel watchdog converts a hung response into a denied reply.

---
 rtl/mmu_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_mmu_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_bus_arbiter.sv
`timescale 1ns/1ps
// mmu_bus_arbiter: shares one TileLink-UL bus between the instruction-side (ifu_bus) and
// data-side (lsu_bus) MMUs. One transaction at a time: the grant is held from the A beat
// until the matching D beat. A D-channel watchdog turns a hung response into a denied reply.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin tie-break; when undefined,
// lsu_bus has fixed priority on ties.
module mmu_bus_arbiter #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SizeWidth   = 3,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SinkWidth   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // requester 0: instruction MMU
  input  logic                     ifu_bus_a_valid,
  output logic                     ifu_bus_a_ready,
  input  logic [2:0]               ifu_bus_a_opcode,
  input  logic [2:0]               ifu_bus_a_param,
  input  logic [SizeWidth-1:0]     ifu_bus_a_size,
  input  logic [SourceWidth-1:0]   ifu_bus_a_source,
  input  logic [AddrWidth-1:0]     ifu_bus_a_address,
  input  logic [DataWidth/8-1:0]   ifu_bus_a_mask,
  input  logic [DataWidth-1:0]     ifu_bus_a_data,
  input  logic                     ifu_bus_a_corrupt,
  output logic                     ifu_bus_d_valid,
  input  logic                     ifu_bus_d_ready,
  output logic [2:0]               ifu_bus_d_opcode,
  output logic [1:0]               ifu_bus_d_param,
  output logic [SizeWidth-1:0]     ifu_bus_d_size,
  output logic [SourceWidth-1:0]   ifu_bus_d_source,
  output logic [SinkWidth-1:0]     ifu_bus_d_sink,
  output logic                     ifu_bus_d_denied,
  output logic [DataWidth-1:0]     ifu_bus_d_data,
  output logic                     ifu_bus_d_corrupt,
  // requester 1: data MMU
  input  logic                     lsu_bus_a_valid,
  output logic                     lsu_bus_a_ready,
  input  logic [2:0]               lsu_bus_a_opcode,
  input  logic [2:0]               lsu_bus_a_param,
  input  logic [SizeWidth-1:0]     lsu_bus_a_size,
  input  logic [SourceWidth-1:0]   lsu_bus_a_source,
  input  logic [AddrWidth-1:0]     lsu_bus_a_address,
  input  logic [DataWidth/8-1:0]   lsu_bus_a_mask,
  input  logic [DataWidth-1:0]     lsu_bus_a_data,
  input  logic                     lsu_bus_a_corrupt,
  output logic                     lsu_bus_d_valid,
  input  logic                     lsu_bus_d_ready,
  output logic [2:0]               lsu_bus_d_opcode,
  output logic [1:0]               lsu_bus_d_param,
  output logic [SizeWidth-1:0]     lsu_bus_d_size,
  output logic [SourceWidth-1:0]   lsu_bus_d_source,
  output logic [SinkWidth-1:0]     lsu_bus_d_sink,
  output logic                     lsu_bus_d_denied,
  output logic [DataWidth-1:0]     lsu_bus_d_data,
  output logic                     lsu_bus_d_corrupt,
  // shared downstream bus
  output logic                     phy_bus_a_valid,
  input  logic                     phy_bus_a_ready,
  output logic [2:0]               phy_bus_a_opcode,
  output logic [2:0]               phy_bus_a_param,
  output logic [SizeWidth-1:0]     phy_bus_a_size,
  output logic [SourceWidth-1:0]   phy_bus_a_source,
  output logic [AddrWidth-1:0]     phy_bus_a_address,
  output logic [DataWidth/8-1:0]   phy_bus_a_mask,
  output logic [DataWidth-1:0]     phy_bus_a_data,
  output logic                     phy_bus_a_corrupt,
  input  logic                     phy_bus_d_valid,
  output logic                     phy_bus_d_ready,
  input  logic [2:0]               phy_bus_d_opcode,
  input  logic [1:0]               phy_bus_d_param,
  input  logic [SizeWidth-1:0]     phy_bus_d_size,
  input  logic [SourceWidth-1:0]   phy_bus_d_source,
  input  logic [SinkWidth-1:0]     phy_bus_d_sink,
  input  logic                     phy_bus_d_denied,
  input  logic [DataWidth-1:0]     phy_bus_d_data,
  input  logic                     phy_bus_d_corrupt,
  // status
  output logic [1:0]               grant,
  output logic                     timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StFake} state_e;

  localparam logic [2:0]  OpGet           = 3'd4;
  localparam logic [2:0]  OpAccessAck     = 3'd0;
  localparam logic [2:0]  OpAccessAckData = 3'd1;
  localparam bit          WdEnable        = (TIMEOUT != 0);
  localparam logic [15:0] WdLast          = 16'(TIMEOUT - 1);

  state_e                 state_q;
  logic [1:0]             grant_q;
  logic                   timeout_q;
  logic [15:0]            wd_cnt_q;
  logic [2:0]             lat_opcode_q;
  logic [SizeWidth-1:0]   lat_size_q;
  logic [SourceWidth-1:0] lat_source_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   last_q;  // 1: lsu_bus won the previous arbitration
`endif

  logic [1:0] win_grant;

  // owner-side view, selected by the held grant (grant is one-hot while busy)
  logic                   owner;
  logic                   own_a_valid;
  logic                   own_a_ready;
  logic [2:0]             own_a_opcode;
  logic [2:0]             own_a_param;
  logic [SizeWidth-1:0]   own_a_size;
  logic [SourceWidth-1:0] own_a_source;
  logic [AddrWidth-1:0]   own_a_address;
  logic [DataWidth/8-1:0] own_a_mask;
  logic [DataWidth-1:0]   own_a_data;
  logic                   own_a_corrupt;
  logic                   own_d_ready;
  logic                   own_d_valid;
  logic [2:0]             own_d_opcode;
  logic [1:0]             own_d_param;
  logic [SizeWidth-1:0]   own_d_size;
  logic [SourceWidth-1:0] own_d_source;
  logic [SinkWidth-1:0]   own_d_sink;
  logic                   own_d_denied;
  logic [DataWidth-1:0]   own_d_data;
  logic                   own_d_corrupt;

  assign owner         = grant_q[1];
  assign own_a_valid   = owner ? lsu_bus_a_valid   : ifu_bus_a_valid;
  assign own_a_opcode  = owner ? lsu_bus_a_opcode  : ifu_bus_a_opcode;
  assign own_a_param   = owner ? lsu_bus_a_param   : ifu_bus_a_param;
  assign own_a_size    = owner ? lsu_bus_a_size    : ifu_bus_a_size;
  assign own_a_source  = owner ? lsu_bus_a_source  : ifu_bus_a_source;
  assign own_a_address = owner ? lsu_bus_a_address : ifu_bus_a_address;
  assign own_a_mask    = owner ? lsu_bus_a_mask    : ifu_bus_a_mask;
  assign own_a_data    = owner ? lsu_bus_a_data    : ifu_bus_a_data;
  assign own_a_corrupt = owner ? lsu_bus_a_corrupt : ifu_bus_a_corrupt;
  assign own_d_ready   = owner ? lsu_bus_d_ready   : ifu_bus_d_ready;

  // Arbitration: a lone requester wins; ties go to the tie-break policy.
  always_comb begin
    win_grant = 2'b00;
    if (ifu_bus_a_valid && lsu_bus_a_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_grant = last_q ? 2'b01 : 2'b10;
`else
      win_grant = 2'b10;
`endif
    end else if (ifu_bus_a_valid) begin
      win_grant = 2'b01;
    end else if (lsu_bus_a_valid) begin
      win_grant = 2'b10;
    end
  end

  // Control FSM with registered grant, timeout pulse, watchdog and latched A fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      timeout_q    <= 1'b0;
      wd_cnt_q     <= '0;
      lat_opcode_q <= '0;
      lat_size_q   <= '0;
      lat_source_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|win_grant) begin
            grant_q <= win_grant;
            state_q <= StReq;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= win_grant[1];
`endif
          end
        end
        StReq: begin
          if (own_a_valid && phy_bus_a_ready) begin
            lat_opcode_q <= own_a_opcode;
            lat_size_q   <= own_a_size;
            lat_source_q <= own_a_source;
            wd_cnt_q     <= '0;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (phy_bus_d_valid && own_d_ready) begin
            grant_q <= 2'b00;
            state_q <= StIdle;
          end else if (!phy_bus_d_valid) begin
            // A beat stalled by the owner's d_ready is not a hang, so only idle cycles count.
            if (WdEnable && (wd_cnt_q == WdLast)) begin
              timeout_q <= 1'b1;
              state_q   <= StFake;
            end else begin
              wd_cnt_q <= wd_cnt_q + 16'd1;
            end
          end
        end
        StFake: begin
          if (own_d_ready) begin
            grant_q <= 2'b00;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A channel: forward the owner's beat only while in StReq; otherwise the bus is quiet.
  always_comb begin
    phy_bus_a_valid   = 1'b0;
    phy_bus_a_opcode  = '0;
    phy_bus_a_param   = '0;
    phy_bus_a_size    = '0;
    phy_bus_a_source  = '0;
    phy_bus_a_address = '0;
    phy_bus_a_mask    = '0;
    phy_bus_a_data    = '0;
    phy_bus_a_corrupt = 1'b0;
    own_a_ready       = 1'b0;
    if (state_q == StReq) begin
      phy_bus_a_valid   = own_a_valid;
      phy_bus_a_opcode  = own_a_opcode;
      phy_bus_a_param   = own_a_param;
      phy_bus_a_size    = own_a_size;
      phy_bus_a_source  = own_a_source;
      phy_bus_a_address = own_a_address;
      phy_bus_a_mask    = own_a_mask;
      phy_bus_a_data    = own_a_data;
      phy_bus_a_corrupt = own_a_corrupt;
      own_a_ready       = phy_bus_a_ready;
    end
  end

  // D channel: pass through in StResp, fabricate a denied reply in StFake.
  always_comb begin
    own_d_valid     = 1'b0;
    own_d_opcode    = '0;
    own_d_param     = '0;
    own_d_size      = '0;
    own_d_source    = '0;
    own_d_sink      = '0;
    own_d_denied    = 1'b0;
    own_d_data      = '0;
    own_d_corrupt   = 1'b0;
    phy_bus_d_ready = 1'b0;
    unique case (state_q)
      StResp: begin
        own_d_valid     = phy_bus_d_valid;
        own_d_opcode    = phy_bus_d_opcode;
        own_d_param     = phy_bus_d_param;
        own_d_size      = phy_bus_d_size;
        own_d_source    = phy_bus_d_source;
        own_d_sink      = phy_bus_d_sink;
        own_d_denied    = phy_bus_d_denied;
        own_d_data      = phy_bus_d_data;
        own_d_corrupt   = phy_bus_d_corrupt;
        phy_bus_d_ready = own_d_ready;
      end
      StFake: begin
        own_d_valid     = 1'b1;
        own_d_opcode    = (lat_opcode_q == OpGet) ? OpAccessAckData : OpAccessAck;
        own_d_size      = lat_size_q;
        own_d_source    = lat_source_q;
        own_d_denied    = 1'b1;
        // Swallow any late beat from the slave so it cannot wedge the bus.
        phy_bus_d_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Fan-out to requesters: the non-owner sees an inert bus.
  assign ifu_bus_a_ready   = grant_q[0] & own_a_ready;
  assign ifu_bus_d_valid   = grant_q[0] & own_d_valid;
  assign ifu_bus_d_opcode  = grant_q[0] ? own_d_opcode  : '0;
  assign ifu_bus_d_param   = grant_q[0] ? own_d_param   : '0;
  assign ifu_bus_d_size    = grant_q[0] ? own_d_size    : '0;
  assign ifu_bus_d_source  = grant_q[0] ? own_d_source  : '0;
  assign ifu_bus_d_sink    = grant_q[0] ? own_d_sink    : '0;
  assign ifu_bus_d_denied  = grant_q[0] & own_d_denied;
  assign ifu_bus_d_data    = grant_q[0] ? own_d_data    : '0;
  assign ifu_bus_d_corrupt = grant_q[0] & own_d_corrupt;

  assign lsu_bus_a_ready   = grant_q[1] & own_a_ready;
  assign lsu_bus_d_valid   = grant_q[1] & own_d_valid;
  assign lsu_bus_d_opcode  = grant_q[1] ? own_d_opcode  : '0;
  assign lsu_bus_d_param   = grant_q[1] ? own_d_param   : '0;
  assign lsu_bus_d_size    = grant_q[1] ? own_d_size    : '0;
  assign lsu_bus_d_source  = grant_q[1] ? own_d_source  : '0;
  assign lsu_bus_d_sink    = grant_q[1] ? own_d_sink    : '0;
  assign lsu_bus_d_denied  = grant_q[1] & own_d_denied;
  assign lsu_bus_d_data    = grant_q[1] ? own_d_data    : '0;
  assign lsu_bus_d_corrupt = grant_q[1] & own_d_corrupt;

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
`timescale 1ns/1ps
// tb_mmu_bus_arbiter: directed and randomized transactions on both requesters, with a
// transaction-level model of who should win and what each bus should show per phase.
module tb_mmu_bus_arbiter;

  localparam int unsigned TO    = 8;
  localparam logic [2:0]  OpGet = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // requester side, index 0 = ifu_bus, 1 = lsu_bus
  logic        a_valid   [2];
  logic        a_ready   [2];
  logic [2:0]  a_opcode  [2];
  logic [2:0]  a_param   [2];
  logic [2:0]  a_size    [2];
  logic [3:0]  a_source  [2];
  logic [31:0] a_address [2];
  logic [7:0]  a_mask    [2];
  logic [63:0] a_data    [2];
  logic        a_corrupt [2];
  logic        d_valid   [2];
  logic        d_ready   [2];
  logic [2:0]  d_opcode  [2];
  logic [1:0]  d_param   [2];
  logic [2:0]  d_size    [2];
  logic [3:0]  d_source  [2];
  logic        d_sink    [2];
  logic        d_denied  [2];
  logic [63:0] d_data    [2];
  logic        d_corrupt [2];

  // downstream side
  logic        p_a_valid, p_a_ready, p_a_corrupt;
  logic [2:0]  p_a_opcode, p_a_param, p_a_size;
  logic [3:0]  p_a_source;
  logic [31:0] p_a_address;
  logic [7:0]  p_a_mask;
  logic [63:0] p_a_data;
  logic        p_d_valid, p_d_ready, p_d_sink, p_d_denied, p_d_corrupt;
  logic [2:0]  p_d_opcode, p_d_size;
  logic [1:0]  p_d_param;
  logic [3:0]  p_d_source;
  logic [63:0] p_d_data;

  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  logic [1:0] pend = 2'b00;  // requesters currently holding a_valid
`ifdef ARB_ROUND_ROBIN_EN
  int last_w = 1;
`endif

  mmu_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_bus_a_valid(a_valid[0]), .ifu_bus_a_ready(a_ready[0]),
    .ifu_bus_a_opcode(a_opcode[0]), .ifu_bus_a_param(a_param[0]), .ifu_bus_a_size(a_size[0]),
    .ifu_bus_a_source(a_source[0]), .ifu_bus_a_address(a_address[0]),
    .ifu_bus_a_mask(a_mask[0]), .ifu_bus_a_data(a_data[0]), .ifu_bus_a_corrupt(a_corrupt[0]),
    .ifu_bus_d_valid(d_valid[0]), .ifu_bus_d_ready(d_ready[0]),
    .ifu_bus_d_opcode(d_opcode[0]), .ifu_bus_d_param(d_param[0]), .ifu_bus_d_size(d_size[0]),
    .ifu_bus_d_source(d_source[0]), .ifu_bus_d_sink(d_sink[0]),
    .ifu_bus_d_denied(d_denied[0]), .ifu_bus_d_data(d_data[0]),
    .ifu_bus_d_corrupt(d_corrupt[0]),
    .lsu_bus_a_valid(a_valid[1]), .lsu_bus_a_ready(a_ready[1]),
    .lsu_bus_a_opcode(a_opcode[1]), .lsu_bus_a_param(a_param[1]), .lsu_bus_a_size(a_size[1]),
    .lsu_bus_a_source(a_source[1]), .lsu_bus_a_address(a_address[1]),
    .lsu_bus_a_mask(a_mask[1]), .lsu_bus_a_data(a_data[1]), .lsu_bus_a_corrupt(a_corrupt[1]),
    .lsu_bus_d_valid(d_valid[1]), .lsu_bus_d_ready(d_ready[1]),
    .lsu_bus_d_opcode(d_opcode[1]), .lsu_bus_d_param(d_param[1]), .lsu_bus_d_size(d_size[1]),
    .lsu_bus_d_source(d_source[1]), .lsu_bus_d_sink(d_sink[1]),
    .lsu_bus_d_denied(d_denied[1]), .lsu_bus_d_data(d_data[1]),
    .lsu_bus_d_corrupt(d_corrupt[1]),
    .phy_bus_a_valid(p_a_valid), .phy_bus_a_ready(p_a_ready),
    .phy_bus_a_opcode(p_a_opcode), .phy_bus_a_param(p_a_param), .phy_bus_a_size(p_a_size),
    .phy_bus_a_source(p_a_source), .phy_bus_a_address(p_a_address),
    .phy_bus_a_mask(p_a_mask), .phy_bus_a_data(p_a_data), .phy_bus_a_corrupt(p_a_corrupt),
    .phy_bus_d_valid(p_d_valid), .phy_bus_d_ready(p_d_ready),
    .phy_bus_d_opcode(p_d_opcode), .phy_bus_d_param(p_d_param), .phy_bus_d_size(p_d_size),
    .phy_bus_d_source(p_d_source), .phy_bus_d_sink(p_d_sink),
    .phy_bus_d_denied(p_d_denied), .phy_bus_d_data(p_d_data), .phy_bus_d_corrupt(p_d_corrupt),
    .grant(grant), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int r);
    a_valid[r]   = 1'b1;
    a_opcode[r]  = ($urandom_range(0, 1) == 1) ? OpGet : 3'd0;
    a_param[r]   = 3'd0;
    a_size[r]    = 3'($urandom_range(0, 3));
    a_source[r]  = 4'($urandom);
    a_address[r] = $urandom;
    a_mask[r]    = 8'hff;
    a_data[r]    = {$urandom, $urandom};
    a_corrupt[r] = 1'b0;
    pend[r]      = 1'b1;
  endtask

  // One full transaction, starting at a negedge while the arbiter is idle and ending at the
  // negedge after completion. d_wait >= TO means the slave never answers.
  task automatic do_txn(input logic [1:0] mask, input int a_wait, input int d_wait,
                        input int rdy_wait, input logic [63:0] rdata);
    int w;
    int o;
    logic [1:0] g_exp;
    logic [2:0] rop;
    logic       rden;
    logic       dv;
    logic       dr;
    for (int r = 0; r < 2; r++) if (mask[r] && !pend[r]) new_req(r);
    if (pend == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = (last_w == 1) ? 0 : 1;
`else
      w = 1;
`endif
    end else begin
      w = pend[1] ? 1 : 0;
    end
`ifdef ARB_ROUND_ROBIN_EN
    last_w = w;
`endif
    o     = 1 - w;
    g_exp = (w == 0) ? 2'b01 : 2'b10;
    rop   = (a_opcode[w] == OpGet) ? 3'd1 : 3'd0;
    rden  = 1'($urandom_range(0, 1));
    d_ready[o] = 1'b1;  // non-owner readiness must never reach phy_bus
    #1;
    chk("arb_grant", grant, 2'b00);
    chk("arb_phy_a_valid", p_a_valid, 1'b0);
    @(posedge clk);
    for (int k = 0; k <= a_wait; k++) begin
      @(negedge clk);
      p_a_ready = (k == a_wait);
      #1;
      chk("req_grant", grant, g_exp);
      chk("req_phy_a_valid", p_a_valid, 1'b1);
      chk("req_phy_a_address", p_a_address, a_address[w]);
      chk("req_phy_a_opcode", p_a_opcode, a_opcode[w]);
      chk("req_phy_a_source", p_a_source, a_source[w]);
      chk("req_phy_a_data", p_a_data, a_data[w]);
      chk("req_own_a_ready", a_ready[w], (k == a_wait));
      chk("req_other_a_ready", a_ready[o], 1'b0);
      chk("req_phy_d_ready", p_d_ready, 1'b0);
      @(posedge clk);
    end
    if (d_wait >= int'(TO)) begin
      for (int k = 0; k < int'(TO); k++) begin
        @(negedge clk);
        if (k == 0) begin a_valid[w] = 1'b0; pend[w] = 1'b0; p_a_ready = 1'b0; end
        p_d_valid = 1'b0;
        #1;
        chk("wd_grant", grant, g_exp);
        chk("wd_own_d_valid", d_valid[w], 1'b0);
        chk("wd_timeout_low", timeout, 1'b0);
        @(posedge clk);
      end
      @(negedge clk);
      d_ready[w] = 1'b0;
      #1;
      chk("fake_timeout", timeout, 1'b1);
      chk("fake_d_valid", d_valid[w], 1'b1);
      chk("fake_d_denied", d_denied[w], 1'b1);
      chk("fake_d_opcode", d_opcode[w], rop);
      chk("fake_d_source", d_source[w], a_source[w]);
      chk("fake_d_size", d_size[w], a_size[w]);
      chk("fake_d_data", d_data[w], 64'd0);
      chk("fake_phy_d_ready", p_d_ready, 1'b1);
      chk("fake_other_d_valid", d_valid[o], 1'b0);
      @(posedge clk);
      @(negedge clk);
      d_ready[w] = 1'b1;
      #1;
      chk("fake_timeout_pulse", timeout, 1'b0);
      chk("fake_d_valid_hold", d_valid[w], 1'b1);
      chk("fake_grant", grant, g_exp);
      @(posedge clk);
    end else begin
      for (int k = 0; k <= d_wait + rdy_wait; k++) begin
        @(negedge clk);
        if (k == 0) begin a_valid[w] = 1'b0; pend[w] = 1'b0; p_a_ready = 1'b0; end
        dv = (k >= d_wait);
        dr = (k == d_wait + rdy_wait);
        p_d_valid   = dv;
        p_d_opcode  = rop;
        p_d_size    = a_size[w];
        p_d_source  = a_source[w];
        p_d_denied  = rden;
        p_d_data    = rdata;
        d_ready[w]  = dr;
        #1;
        chk("resp_grant", grant, g_exp);
        chk("resp_own_d_valid", d_valid[w], dv);
        chk("resp_other_d_valid", d_valid[o], 1'b0);
        chk("resp_other_d_data", d_data[o], 64'd0);
        chk("resp_phy_d_ready", p_d_ready, dr);
        chk("resp_phy_a_valid", p_a_valid, 1'b0);
        chk("resp_timeout", timeout, 1'b0);
        if (dv) begin
          chk("resp_d_data", d_data[w], rdata);
          chk("resp_d_source", d_source[w], a_source[w]);
          chk("resp_d_opcode", d_opcode[w], rop);
          chk("resp_d_denied", d_denied[w], rden);
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    p_d_valid  = 1'b0;
    d_ready[0] = 1'b0;
    d_ready[1] = 1'b0;
    #1;
    chk("done_grant", grant, 2'b00);
    chk("done_own_d_valid", d_valid[w], 1'b0);
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      a_valid[r] = 0; a_opcode[r] = 0; a_param[r] = 0; a_size[r] = 0; a_source[r] = 0;
      a_address[r] = 0; a_mask[r] = 0; a_data[r] = 0; a_corrupt[r] = 0; d_ready[r] = 0;
    end
    p_a_ready = 0; p_d_valid = 0; p_d_opcode = 0; p_d_param = 0; p_d_size = 0;
    p_d_source = 0; p_d_sink = 0; p_d_denied = 0; p_d_data = 0; p_d_corrupt = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_phy_a_valid", p_a_valid, 1'b0);
    chk("rst_phy_d_ready", p_d_ready, 1'b0);
    chk("rst_ifu_a_ready", a_ready[0], 1'b0);
    chk("rst_lsu_d_valid", d_valid[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single ifu Get with immediate accept and next-cycle data
    new_req(0);
    a_opcode[0]  = OpGet;
    a_address[0] = 32'h8000_0000;
    do_txn(2'b01, 0, 0, 0, 64'h1122_3344_5566_7788);

    // three back-to-back ties
    for (int i = 0; i < 3; i++) do_txn(2'b11, 0, 0, 0, {$urandom, $urandom});
    while (pend != 2'b00) do_txn(2'b00, 0, 0, 0, {$urandom, $urandom});

    // slave stalls A for 5 cycles
    do_txn(2'b01, 5, 1, 0, {$urandom, $urandom});

    // lsu Get, source 3, slave never answers
    new_req(1);
    a_opcode[1] = OpGet;
    a_source[1] = 4'd3;
    do_txn(2'b10, 0, TO, 0, 64'd0);

    // owner stalls D for 4 cycles while the beat is valid
    do_txn(2'b01, 0, 1, 4, {$urandom, $urandom});

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      int dw;
      dw = ($urandom_range(0, 5) == 0) ? int'(TO) : int'($urandom_range(0, 5));
      do_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), dw,
             int'($urandom_range(0, 3)), {$urandom, $urandom});
    end
    while (pend != 2'b00) do_txn(2'b00, 0, 0, 0, {$urandom, $urandom});

    // reset in the middle of a response wait, ifu keeps requesting through it
    new_req(0);
    @(posedge clk);
    @(negedge clk);
    p_a_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    p_a_ready = 1'b0;
    #1;
    chk("mid_grant_before_rst", grant, 2'b01);
    rst_n     = 1'b0;
    p_d_valid = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_phy_a_valid", p_a_valid, 1'b0);
    chk("mid_rst_phy_a_address", p_a_address, 32'd0);
    chk("mid_rst_ifu_d_valid", d_valid[0], 1'b0);
    chk("mid_rst_phy_d_ready", p_d_ready, 1'b0);
    p_d_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_w = 1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(2'b01, 0, 0, 0, {$urandom, $urandom});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
